// File: rtl/mcu_pkg.sv
// mcu_pkg: shared definitions for the MCU control sequencer.
//   ST_LOAD/ST_RUN/ST_STORE : top-level state encodings (also the MUX_ARRAY i_state code)
//   state_t                 : FSM state type
//   state_w/substate_w/memsel_w : select widths shared with MUX_ARRAY
package mcu_pkg;
    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_STORE = 2'd2;

    typedef enum logic [1:0] {
        S_LOAD  = ST_LOAD,
        S_RUN   = ST_RUN,
        S_STORE = ST_STORE
    } state_t;

    function automatic int state_w(input int states);
        return (states > 1) ? $clog2(states) : 1;
    endfunction

    function automatic int substate_w(input int n);
        return $clog2(n / 2 + 1) + 1;
    endfunction

    function automatic int memsel_w(input int n);
        return $clog2(n + 2);
    endfunction
endpackage

// File: rtl/mcu_ctrl_fsm_if.sv
// mcu_ctrl_fsm_if: controller-side bus of the MCU sequencer.
//   master : the sequencer (drives selects, addresses, enables, handshakes)
//   slave  : the datapath/environment (drives rows, load valid, result ready)
interface mcu_ctrl_fsm_if import mcu_pkg::*; #(
    parameter int N         = 2,
    parameter int BITS_ADDR = 10,
    parameter int STATES    = 3
) ();
    localparam int SW   = state_w(STATES);
    localparam int SUBW = substate_w(N);
    localparam int MSW  = memsel_w(N);

    logic [BITS_ADDR-1:0] i_rows;
    logic                 i_valid;
    logic                 o_ready;
    logic [SW-1:0]        o_state;
    logic [SUBW-1:0]      o_substate;
    logic [MSW-1:0]       o_memSelect;
    logic [BITS_ADDR-1:0] o_rd_addr;
    logic [BITS_ADDR-1:0] o_wr_addr;
    logic                 o_we;
    logic                 o_conv_en;
    logic                 o_out_valid;
    logic                 i_out_ready;
    logic                 o_pass_done;

    modport master (
        input  i_rows, i_valid, i_out_ready,
        output o_ready, o_state, o_substate, o_memSelect, o_rd_addr, o_wr_addr,
               o_we, o_conv_en, o_out_valid, o_pass_done
    );

    modport slave (
        output i_rows, i_valid, i_out_ready,
        input  o_ready, o_state, o_substate, o_memSelect, o_rd_addr, o_wr_addr,
               o_we, o_conv_en, o_out_valid, o_pass_done
    );
endinterface

// File: rtl/mcu_wrap_counter.sv
// mcu_wrap_counter: up-counter with programmable terminal value.
//   i_en   : advance one step     i_clr : synchronous clear (wins over i_en)
//   i_last : terminal value        o_cnt : current count
//   o_wrap : combinational, high on an enabled step at the terminal value
module mcu_wrap_counter import mcu_pkg::*; #(
    parameter int W = 4
) (
    input  logic         i_clock,
    input  logic         i_reset_n,
    input  logic         i_en,
    input  logic         i_clr,
    input  logic [W-1:0] i_last,
    output logic [W-1:0] o_cnt,
    output logic         o_wrap
);
    assign o_wrap = i_en && (o_cnt == i_last);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n)  o_cnt <= '0;
        else if (i_clr)  o_cnt <= '0;
        else if (i_en)   o_cnt <= o_wrap ? '0 : o_cnt + 1'b1;
    end
endmodule

// File: rtl/mcu_ctrl_fsm.sv
// mcu_ctrl_fsm: LOAD -> RUN -> STORE sequencer for the 2D-convolution MCU.
//   i_clock, i_reset_n : clock, async active-low reset
//   bus (master)       : rows/valid/ready load handshake, MUX selects,
//                        memory addresses/write enable, convolver enable,
//                        result handshake and end-of-pass pulse
// One row counter serves as write address (LOAD), read address (RUN/STORE);
// one memSelect counter walks the column memories in LOAD and STORE.
module mcu_ctrl_fsm import mcu_pkg::*; #(
    parameter int N           = 2,
    parameter int BITS_IMAGEN = 8,
    parameter int STATES      = 3,
    parameter int BITS_ADDR   = 10,
    parameter int LAT         = 2
) (
    input  logic          i_clock,
    input  logic          i_reset_n,
    mcu_ctrl_fsm_if.master bus
);
    localparam int SW   = state_w(STATES);
    localparam int SUBW = substate_w(N);
    localparam int MSW  = memsel_w(N);
    localparam logic [MSW-1:0]  MS_FULL_LAST = MSW'(N + 1);
    localparam logic [MSW-1:0]  MS_PART_LAST = MSW'(N - 1);
    localparam logic [SUBW-1:0] SUB_LAST     = SUBW'(N / 2);

    if ((N % 2) != 0 || N < 2 || LAT < 1 || BITS_IMAGEN < 1) begin : g_param_check
        $error("mcu_ctrl_fsm: N must be even and >= 2, LAT >= 1");
    end

    state_t               state;
    logic                 ready_q, conv_en_q, out_valid_q, pass_done_q;
    logic                 full_q, rows_vld_q;
    logic [BITS_ADDR-1:0] rows_m1_q, rows_m1;
    logic [SUBW-1:0]      sub_q;
    logic [LAT-1:0]                wb_vld;
    logic [LAT-1:0][BITS_ADDR-1:0] wb_addr;

    logic                 in_load, in_run, in_store;
    logic                 load_fire, store_fire, load_done, store_done, run_done;
    logic                 row_en, row_clr, row_wrap, mem_en, mem_wrap;
    logic [BITS_ADDR-1:0] row_cnt;
    logic [MSW-1:0]       mem_cnt, mem_last;

    assign in_load  = (state == S_LOAD);
    assign in_run   = (state == S_RUN);
    assign in_store = (state == S_STORE);

    // First LOAD cycle after entry uses i_rows directly; afterwards the latch.
    assign rows_m1 = rows_vld_q ? rows_m1_q : (bus.i_rows - 1'b1);

    assign load_fire  = in_load && bus.i_valid && ready_q;
    assign store_fire = in_store && out_valid_q && bus.i_out_ready;

    assign row_en   = load_fire || (in_run && conv_en_q) || store_fire;
    assign row_clr  = run_done;
    assign mem_en   = row_wrap && (in_load || in_store);
    assign mem_last = (in_load && full_q) ? MS_FULL_LAST : MS_PART_LAST;

    assign load_done  = load_fire && row_wrap && mem_wrap;
    assign store_done = store_fire && row_wrap && mem_wrap;
    // RUN ends on the write-back of the last row: rows+LAT cycles in total.
    assign run_done   = in_run && wb_vld[LAT-1] && (wb_addr[LAT-1] == rows_m1);

    mcu_wrap_counter #(.W(BITS_ADDR)) u_row_cnt (
        .i_clock(i_clock), .i_reset_n(i_reset_n), .i_en(row_en), .i_clr(row_clr),
        .i_last(rows_m1), .o_cnt(row_cnt), .o_wrap(row_wrap)
    );

    mcu_wrap_counter #(.W(MSW)) u_mem_cnt (
        .i_clock(i_clock), .i_reset_n(i_reset_n), .i_en(mem_en), .i_clr(in_run),
        .i_last(mem_last), .o_cnt(mem_cnt), .o_wrap(mem_wrap)
    );

    // Write-back delay line: the read issued on RUN cycle k retires on k+LAT.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wb_vld  <= '0;
            wb_addr <= '0;
        end else begin
            wb_vld[0]  <= conv_en_q;
            wb_addr[0] <= conv_en_q ? row_cnt : '0;
            for (int i = 1; i < LAT; i++) begin
                wb_vld[i]  <= wb_vld[i-1];
                wb_addr[i] <= wb_addr[i-1];
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= S_LOAD;
            ready_q     <= 1'b1;
            conv_en_q   <= 1'b0;
            out_valid_q <= 1'b0;
            pass_done_q <= 1'b0;
            full_q      <= 1'b1;
            rows_vld_q  <= 1'b0;
            rows_m1_q   <= '0;
            sub_q       <= '0;
        end else begin
            pass_done_q <= 1'b0;
            case (state)
                S_LOAD: begin
                    if (!rows_vld_q) begin
                        rows_m1_q  <= rows_m1;
                        rows_vld_q <= 1'b1;
                    end
                    if (load_done) begin
                        state     <= S_RUN;
                        ready_q   <= 1'b0;
                        conv_en_q <= 1'b1;
                        full_q    <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (conv_en_q && row_wrap) conv_en_q <= 1'b0;
                    if (run_done) begin
                        state       <= S_STORE;
                        out_valid_q <= 1'b0;
                    end
                end
                S_STORE: begin
                    // Address presented with valid low for one read-latency cycle.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (store_fire) begin
                        out_valid_q <= 1'b0;
                        if (store_done) begin
                            state       <= S_LOAD;
                            ready_q     <= 1'b1;
                            pass_done_q <= 1'b1;
                            rows_vld_q  <= 1'b0;
                            sub_q       <= (sub_q == SUB_LAST) ? '0 : sub_q + 1'b1;
                        end
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

    assign bus.o_state     = SW'(state);
    assign bus.o_substate  = sub_q;
    assign bus.o_memSelect = mem_cnt;
    assign bus.o_ready     = ready_q;
    assign bus.o_conv_en   = conv_en_q;
    assign bus.o_out_valid = out_valid_q;
    assign bus.o_pass_done = pass_done_q;
    assign bus.o_rd_addr   = in_load ? '0 : row_cnt;
    assign bus.o_wr_addr   = in_load ? row_cnt : (in_run ? wb_addr[LAT-1] : '0);
    assign bus.o_we        = in_load ? load_fire : (in_run && wb_vld[LAT-1]);
endmodule

// File: tb/tb_mcu_ctrl_fsm.sv
module tb_mcu_ctrl_fsm;
    import mcu_pkg::*;

    localparam int N = 2, BA = 10, LAT = 2, STATES = 3, ROWS = 4;

    logic i_clock = 1'b0;
    logic i_reset_n = 1'b0;
    always #5 i_clock = ~i_clock;

    mcu_ctrl_fsm_if #(.N(N), .BITS_ADDR(BA), .STATES(STATES)) bus ();

    mcu_ctrl_fsm #(.N(N), .BITS_IMAGEN(8), .STATES(STATES), .BITS_ADDR(BA), .LAT(LAT)) dut (
        .i_clock(i_clock), .i_reset_n(i_reset_n), .bus(bus)
    );

    // Expected fields of -1 are not compared.
    typedef struct packed {
        logic va; logic orr;
        int st; int ms; int rd; int wr; int we; int rdy; int cen; int ov; int pd; int sub;
    } vec_t;

    vec_t tbl[$];
    int n_vec = 0;
    int n_bad = 0;

    function automatic vec_t mk(logic va, logic orr, int st, int ms, int rd, int wr,
                                int we, int rdy, int cen, int ov, int pd, int sub);
        vec_t v;
        v.va = va; v.orr = orr; v.st = st; v.ms = ms; v.rd = rd; v.wr = wr;
        v.we = we; v.rdy = rdy; v.cen = cen; v.ov = ov; v.pd = pd; v.sub = sub;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic chk_opt(input string name, input logic [31:0] act, input int exp);
        if (exp >= 0) chk(name, act, exp);
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge i_clock);
        bus.i_valid = v.va;
        bus.i_out_ready = v.orr;
        #1;
        chk_opt($sformatf("v%0d.state", idx), bus.o_state, v.st);
        chk_opt($sformatf("v%0d.memSelect", idx), bus.o_memSelect, v.ms);
        chk_opt($sformatf("v%0d.rd_addr", idx), bus.o_rd_addr, v.rd);
        chk_opt($sformatf("v%0d.wr_addr", idx), bus.o_wr_addr, v.wr);
        chk_opt($sformatf("v%0d.we", idx), bus.o_we, v.we);
        chk_opt($sformatf("v%0d.ready", idx), bus.o_ready, v.rdy);
        chk_opt($sformatf("v%0d.conv_en", idx), bus.o_conv_en, v.cen);
        chk_opt($sformatf("v%0d.out_valid", idx), bus.o_out_valid, v.ov);
        chk_opt($sformatf("v%0d.pass_done", idx), bus.o_pass_done, v.pd);
        chk_opt($sformatf("v%0d.substate", idx), bus.o_substate, v.sub);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".state"}, bus.o_state, 0);
        chk({tag, ".substate"}, bus.o_substate, 0);
        chk({tag, ".memSelect"}, bus.o_memSelect, 0);
        chk({tag, ".ready"}, bus.o_ready, 1);
        chk({tag, ".we"}, bus.o_we, 0);
        chk({tag, ".conv_en"}, bus.o_conv_en, 0);
        chk({tag, ".out_valid"}, bus.o_out_valid, 0);
        chk({tag, ".pass_done"}, bus.o_pass_done, 0);
        chk({tag, ".wr_addr"}, bus.o_wr_addr, 0);
        chk({tag, ".rd_addr"}, bus.o_rd_addr, 0);
    endtask

    // n back-to-back load beats, then confirm the fill ended in RUN.
    task automatic load_beats(input int n, input string tag);
        for (int j = 0; j < n; j++) begin
            @(negedge i_clock);
            bus.i_valid = 1'b1;
            #1;
            chk($sformatf("%s.b%0d.state", tag, j), bus.o_state, 0);
            chk($sformatf("%s.b%0d.memSelect", tag, j), bus.o_memSelect, j / ROWS);
            chk($sformatf("%s.b%0d.wr_addr", tag, j), bus.o_wr_addr, j % ROWS);
            chk($sformatf("%s.b%0d.we", tag, j), bus.o_we, 1);
            chk($sformatf("%s.b%0d.ready", tag, j), bus.o_ready, 1);
        end
        @(negedge i_clock);
        bus.i_valid = 1'b0;
        #1;
        chk({tag, ".end.state"}, bus.o_state, 1);
        chk({tag, ".end.ready"}, bus.o_ready, 0);
    endtask

    // Run RUN+STORE with ready always high; i_rows is disturbed mid-pass.
    task automatic finish_pass(input int exp_sub, input string tag);
        int fires = 0;
        int cyc = 0;
        bit done = 1'b0;
        bus.i_rows = 10'd9;
        bus.i_out_ready = 1'b1;
        while (!done && cyc < 200) begin
            @(negedge i_clock);
            #1;
            if (bus.o_out_valid && bus.i_out_ready) fires++;
            if (bus.o_pass_done) done = 1'b1;
            cyc++;
        end
        bus.i_rows = 10'(ROWS);
        bus.i_out_ready = 1'b0;
        chk({tag, ".pass_done_seen"}, done, 1);
        chk({tag, ".fires"}, fires, N * ROWS);
        chk({tag, ".substate"}, bus.o_substate, exp_sub);
        chk({tag, ".state"}, bus.o_state, 0);
        chk({tag, ".ready"}, bus.o_ready, 1);
    endtask

    initial begin
        int we_seen;
        bus.i_rows = 10'(ROWS);
        bus.i_valid = 1'b0;
        bus.i_out_ready = 1'b0;

        // Pass 1: full fill with a 2-cycle gap before beat 5, then RUN, then STORE
        // with 3 stall cycles on the second beat.
        for (int j = 0; j < (N + 2) * ROWS; j++) begin
            if (j == 4) repeat (2) tbl.push_back(mk(0, 0, 0, 1, -1, 0, 0, 1, 0, 0, 0, 0));
            tbl.push_back(mk(1, 0, 0, j / ROWS, -1, j % ROWS, 1, 1, 0, 0, 0, 0));
        end
        for (int c = 0; c < ROWS + LAT; c++)
            tbl.push_back(mk(1, 1, 1, -1, (c < ROWS) ? c : -1, (c >= LAT) ? c - LAT : -1,
                             (c >= LAT) ? 1 : 0, 0, (c < ROWS) ? 1 : 0, 0, 0, 0));
        for (int b = 0; b < N * ROWS; b++) begin
            tbl.push_back(mk(0, 1, 2, b / ROWS, b % ROWS, -1, 0, 0, 0, 0, 0, 0));
            if (b == 1) repeat (3) tbl.push_back(mk(0, 0, 2, b / ROWS, b % ROWS, -1, 0, 0, 0, 1, 0, 0));
            tbl.push_back(mk(0, 1, 2, b / ROWS, b % ROWS, -1, 0, 0, 0, 1, 0, 0));
        end
        tbl.push_back(mk(0, 0, 0, 0, -1, 0, 0, 1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, -1, 0, 0, 1, 0, 0, 0, 1));

        repeat (3) @(negedge i_clock);
        #1;
        chk_reset_vals("reset");
        @(negedge i_clock);
        i_reset_n = 1'b1;

        foreach (tbl[i]) apply(tbl[i], i);

        // Pass 2 (partial fill, rotation wraps to 0) and pass 3.
        load_beats(N * ROWS, "p2");
        finish_pass(0, "p2");
        load_beats(N * ROWS, "p3");
        finish_pass(1, "p3");

        // Reset during RUN cycle 3 discards write-back and forces a full fill.
        load_beats(N * ROWS, "p4");
        @(negedge i_clock);
        @(negedge i_clock);
        #1;
        chk("p4.run2.we", bus.o_we, 1);
        @(negedge i_clock);
        i_reset_n = 1'b0;
        #1;
        chk_reset_vals("rst_mid_run");
        @(negedge i_clock);
        i_reset_n = 1'b1;
        we_seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge i_clock);
            #1;
            if (bus.o_we) we_seen++;
        end
        chk("rst_mid_run.we_after", we_seen, 0);
        load_beats((N + 2) * ROWS, "refill");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
